// File: rtl/kpn_pkg.sv
// Shared constants for the KPN process nodes: default widths and FSM state codes.
package kpn_pkg;

  localparam int unsigned DEF_BITS_NUMBER      = 16;
  localparam int unsigned DEF_IN_FIFO_ELEMENTS = 2;
  localparam int unsigned PAIR_CNT_W           = 16;

  localparam logic [0:0] S_WAIT_A = 1'b0;
  localparam logic [0:0] S_WAIT_B = 1'b1;

endpackage : kpn_pkg

// File: rtl/kpn_token_fifo.sv
// Small synchronous token FIFO with a combinational head and a drop flag,
// shared by the KPN process nodes.
module kpn_token_fifo
  import kpn_pkg::*;
#(
  parameter int unsigned BITS_NUMBER      = DEF_BITS_NUMBER,
  parameter int unsigned IN_FIFO_ELEMENTS = DEF_IN_FIFO_ELEMENTS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [BITS_NUMBER-1:0] push_data,
  input  logic                   pop,
  output logic [BITS_NUMBER-1:0] head,
  output logic                   empty,
  output logic                   full,
  output logic                   dropped
);

  localparam int unsigned AW    = IN_FIFO_ELEMENTS;
  localparam int unsigned DEPTH = 1 << IN_FIFO_ELEMENTS;
  localparam int unsigned CNT_W = IN_FIFO_ELEMENTS + 1;

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BITS_NUMBER-1:0] mem_q [DEPTH];
  logic [BITS_NUMBER-1:0] mem_d [DEPTH];
  logic                   push_ok;
  logic                   pop_ok;

  assign empty   = (count_q == CNT_W'(0));
  assign full    = (count_q == CNT_W'(DEPTH));
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a token when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign dropped = push & full & ~pop_ok;

  // Pointer, occupancy and storage next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : kpn_token_fifo

// File: rtl/kpn_adder_process.sv
// KPN adder node: pairs consecutive tokens A, B from the input FIFO and
// emits A+B with a one-cycle write strobe towards the downstream queue.
module kpn_adder_process
  import kpn_pkg::*;
#(
  parameter int unsigned BITS_NUMBER      = DEF_BITS_NUMBER,
  parameter int unsigned IN_FIFO_ELEMENTS = DEF_IN_FIFO_ELEMENTS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_in,
  input  logic [BITS_NUMBER-1:0] data_in,
  input  logic                   full_in,
  output logic                   wr_out,
  output logic [BITS_NUMBER-1:0] data_out,
  output logic [PAIR_CNT_W-1:0]  pair_count,
  output logic                   overflow
);

  logic [0:0]             state_q, state_d;
  logic [BITS_NUMBER-1:0] operand_a_q, operand_a_d;
  logic                   wr_out_q, wr_out_d;
  logic [BITS_NUMBER-1:0] data_out_q, data_out_d;
  logic [PAIR_CNT_W-1:0]  pair_count_q, pair_count_d;
  logic                   overflow_q, overflow_d;

  logic                   pop_c;
  logic [BITS_NUMBER-1:0] fifo_head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_dropped;

  kpn_token_fifo #(
    .BITS_NUMBER      (BITS_NUMBER),
    .IN_FIFO_ELEMENTS (IN_FIFO_ELEMENTS)
  ) u_in_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_in),
    .push_data (data_in),
    .pop       (pop_c),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .dropped   (fifo_dropped)
  );

  // Pairing FSM; a B token is only consumed while downstream has room.
  always_comb begin
    state_d      = state_q;
    operand_a_d  = operand_a_q;
    wr_out_d     = 1'b0;
    data_out_d   = data_out_q;
    pair_count_d = pair_count_q;
    overflow_d   = overflow_q | fifo_dropped;
    pop_c        = 1'b0;
    if (state_q == S_WAIT_A) begin
      if (!fifo_empty) begin
        pop_c       = 1'b1;
        operand_a_d = fifo_head;
        state_d     = S_WAIT_B;
      end
    end else begin
      if (!fifo_empty && !full_in) begin
        pop_c        = 1'b1;
        data_out_d   = operand_a_q + fifo_head;
        wr_out_d     = 1'b1;
        pair_count_d = pair_count_q + PAIR_CNT_W'(1);
        state_d      = S_WAIT_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_A;
      operand_a_q  <= '0;
      wr_out_q     <= 1'b0;
      data_out_q   <= '0;
      pair_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      operand_a_q  <= operand_a_d;
      wr_out_q     <= wr_out_d;
      data_out_q   <= data_out_d;
      pair_count_q <= pair_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_out     = wr_out_q;
  assign data_out   = data_out_q;
  assign pair_count = pair_count_q;
  assign overflow   = overflow_q;

endmodule : kpn_adder_process

// File: tb/tb_kpn_adder_process.sv
// Bench for kpn_adder_process: directed scenarios plus random traffic,
// all checked against a token-queue reference model.
module tb_kpn_adder_process;

  logic        clk;
  logic        rst_n;
  logic        wr_in;
  logic [15:0] data_in;
  logic        full_in;
  logic        wr_out;
  logic [15:0] data_out;
  logic [15:0] pair_count;
  logic        overflow;

  int n_err;
  int n_chk;

  // Reference model: a queue of waiting tokens plus an optional held A operand.
  logic [15:0] m_q[$];
  bit          m_have_a;
  logic [15:0] m_a;
  logic        exp_wr;
  logic [15:0] exp_data;
  logic [15:0] exp_cnt;
  logic        exp_ovf;

  kpn_adder_process dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_in      (wr_in),
    .data_in    (data_in),
    .full_in    (full_in),
    .wr_out     (wr_out),
    .data_out   (data_out),
    .pair_count (pair_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model, then sample 1 ns after the edge.
  task automatic step(input bit w, input logic [15:0] d, input bit f, input bit r);
    bit          pop;
    logic [15:0] h;
    wr_in   = w;
    data_in = d;
    full_in = f;
    rst_n   = r;
    if (!r) begin
      m_q.delete();
      m_have_a = 0;
      m_a      = '0;
      exp_wr   = 1'b0;
      exp_data = '0;
      exp_cnt  = '0;
      exp_ovf  = 1'b0;
    end else begin
      pop    = (m_q.size() != 0) && (!m_have_a || !f);
      exp_wr = 1'b0;
      if (pop) begin
        h = m_q.pop_front();
        if (!m_have_a) begin
          m_a      = h;
          m_have_a = 1;
        end else begin
          exp_data = m_a + h;
          exp_wr   = 1'b1;
          exp_cnt  = exp_cnt + 16'd1;
          m_have_a = 0;
        end
      end
      if (w) begin
        if (m_q.size() < 4) m_q.push_back(d);
        else exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    step(1'b1, 16'h5555, 1'b1, 1'b0);
    n_chk++;
    if (wr_out !== 1'b0) begin
      n_err++; $display("FAIL reset_wr_out: got %b want 0", wr_out);
    end
    n_chk++;
    if (data_out !== 16'h0000) begin
      n_err++; $display("FAIL reset_data_out: got %h want 0000", data_out);
    end
    n_chk++;
    if (pair_count !== 16'd0) begin
      n_err++; $display("FAIL reset_pair_count: got %0d want 0", pair_count);
    end
    n_chk++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_basic();
    logic [15:0] sums[$];
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(i < 2, (i == 0) ? 16'h0003 : 16'h0004, 1'b0, 1'b1);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL basic cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
      if (wr_out === 1'b1) sums.push_back(data_out);
    end
    n_chk++;
    if (sums.size() != 1 || data_out !== 16'h0007 || pair_count !== 16'd1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: got pulses=%0d d=%h cnt=%0d ovf=%b want pulses=1 d=0007 cnt=1 ovf=0",
               sums.size(), data_out, pair_count, overflow);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    pulses = 0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(i < 2, (i == 0) ? 16'hFFFF : 16'h0002, 1'b0, 1'b1);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL wrap cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
      if (wr_out === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 1 || data_out !== 16'h0001) begin
      n_err++;
      $display("FAIL wrap_result: got pulses=%0d d=%h want pulses=1 d=0001", pulses, data_out);
    end
  endtask

  task automatic test_stall();
    int          stalled_pulses;
    int          release_pulses;
    int          total_pulses;
    bit          f;
    logic [15:0] d;
    stalled_pulses = 0;
    release_pulses = 0;
    total_pulses   = 0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      f = (i >= 1 && i <= 6);
      d = (i == 0) ? 16'h0100 : 16'h0023;
      step(i == 0 || i == 2, d, f, 1'b1);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL stall cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
      if (wr_out === 1'b1) begin
        total_pulses++;
        if (f) stalled_pulses++;
        if (i == 7) release_pulses++;
      end
    end
    n_chk++;
    if (stalled_pulses != 0 || release_pulses != 1 || total_pulses != 1 || data_out !== 16'h0123) begin
      n_err++;
      $display("FAIL stall_result: got stalled=%0d release=%0d total=%0d d=%h want 0 1 1 0123",
               stalled_pulses, release_pulses, total_pulses, data_out);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] sums[$];
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(i < 8, 16'(i + 1), i < 8, 1'b1);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL overflow cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
      if (i == 7) begin
        n_chk++;
        if (overflow !== 1'b1) begin
          n_err++; $display("FAIL overflow_flag: got %b want 1", overflow);
        end
      end
      if (wr_out === 1'b1) sums.push_back(data_out);
    end
    n_chk++;
    if (sums.size() != 2 || overflow !== 1'b1 || pair_count !== 16'd2) begin
      n_err++;
      $display("FAIL overflow_result: got sums=%0d ovf=%b cnt=%0d want sums=2 ovf=1 cnt=2",
               sums.size(), overflow, pair_count);
    end else begin
      n_chk++;
      if (sums[0] !== 16'd3 || sums[1] !== 16'd7) begin
        n_err++;
        $display("FAIL overflow_order: got %0d,%0d want 3,7", sums[0], sums[1]);
      end
    end
  endtask

  task automatic test_reset_mid_pair();
    int pulses;
    pulses = 0;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0010, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(i < 2, (i == 0) ? 16'h0001 : 16'h0002, 1'b0, 1'b1);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL midreset cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
      if (wr_out === 1'b1) pulses++;
    end
    n_chk++;
    if (pulses != 1 || data_out !== 16'h0003 || pair_count !== 16'd1) begin
      n_err++;
      $display("FAIL midreset_result: got pulses=%0d d=%h cnt=%0d want 1 0003 1",
               pulses, data_out, pair_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] sums[$];
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(i < 8, 16'(i + 1), 1'b0, 1'b1);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL stream cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
      if (wr_out === 1'b1) sums.push_back(data_out);
    end
    n_chk++;
    if (sums.size() != 4 || pair_count !== 16'd4 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL stream_result: got sums=%0d cnt=%0d ovf=%b want 4 4 0",
               sums.size(), pair_count, overflow);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (sums[k] !== 16'(4 * k + 3)) begin
          n_err++;
          $display("FAIL stream_sum%0d: got %0d want %0d", k, sums[k], 4 * k + 3);
        end
      end
    end
  endtask

  task automatic test_random();
    bit          w;
    bit          f;
    bit          r;
    logic [15:0] d;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 70);
      f = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 149) != 0);
      d = 16'($urandom);
      step(w, d, f, r);
      n_chk++;
      if ({wr_out, data_out, pair_count, overflow} !== {exp_wr, exp_data, exp_cnt, exp_ovf}) begin
        n_err++;
        $display("FAIL random cyc%0d: got wr=%b d=%h cnt=%0d ovf=%b want wr=%b d=%h cnt=%0d ovf=%b",
                 i, wr_out, data_out, pair_count, overflow, exp_wr, exp_data, exp_cnt, exp_ovf);
      end
    end
  endtask

  initial begin
    n_err    = 0;
    n_chk    = 0;
    rst_n    = 1'b0;
    wr_in    = 1'b0;
    data_in  = '0;
    full_in  = 1'b0;
    m_have_a = 0;
    m_a      = '0;
    exp_wr   = 1'b0;
    exp_data = '0;
    exp_cnt  = '0;
    exp_ovf  = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_overflow();
    test_reset_mid_pair();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_kpn_adder_process
